// File: rtl/elev_pkg.sv
// Shared encodings for the elevator control path: car controller states,
// sweep directions and the floor index width.
package elev_pkg;

    localparam int FLOOR_W = 3;

    typedef enum logic [1:0] {
        ST_OPEN = 2'd0,
        ST_STOP = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } car_state_t;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

endpackage

// File: rtl/floor_search.sv
// Combinational search of a request vector relative to the current floor:
// nearest and farthest requesting floors above and below.
module floor_search
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = 5
) (
    input  logic [NUM_FLOORS-1:0] req,
    input  logic [FLOOR_W-1:0]    location,
    output logic [FLOOR_W-1:0]    lo_above,
    output logic                  lo_above_found,
    output logic [FLOOR_W-1:0]    hi_above,
    output logic                  hi_above_found,
    output logic [FLOOR_W-1:0]    hi_below,
    output logic                  hi_below_found,
    output logic [FLOOR_W-1:0]    lo_below,
    output logic                  lo_below_found
);

    // Ascending scan: "lo" outputs latch the first hit, "hi" outputs the last.
    always_comb begin
        lo_above       = '0;
        lo_above_found = 1'b0;
        hi_above       = '0;
        hi_above_found = 1'b0;
        hi_below       = '0;
        hi_below_found = 1'b0;
        lo_below       = '0;
        lo_below_found = 1'b0;
        for (int f = 1; f <= NUM_FLOORS; f++) begin
            if (req[f-1] && (FLOOR_W'(f) > location)) begin
                if (!lo_above_found) begin
                    lo_above       = FLOOR_W'(f);
                    lo_above_found = 1'b1;
                end
                hi_above       = FLOOR_W'(f);
                hi_above_found = 1'b1;
            end
            if (req[f-1] && (FLOOR_W'(f) < location)) begin
                if (!lo_below_found) begin
                    lo_below       = FLOOR_W'(f);
                    lo_below_found = 1'b1;
                end
                hi_below       = FLOOR_W'(f);
                hi_below_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_scheduler.sv
// LOOK request scheduler: latches car/hall calls, tracks the sweep direction
// and selects the destination floor handed to the car controller.
module request_scheduler
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [NUM_FLOORS-1:0] car_btn,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_dn,
    input  logic [FLOOR_W-1:0]    location,
    input  logic [1:0]            car_state,
    output logic [FLOOR_W-1:0]    dest,
    output logic [1:0]            dir,
    output logic [NUM_FLOORS-1:0] car_lamp,
    output logic [NUM_FLOORS-1:0] up_lamp,
    output logic [NUM_FLOORS-1:0] dn_lamp,
    output logic                  pending
);

    // No up call exists at the top floor, no down call at the bottom floor.
    localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    dir_t                  dir_q, dir_d;
    logic [FLOOR_W-1:0]    dest_q, dest_d;
    logic [NUM_FLOORS-1:0] all_req, at_loc;
    logic [NUM_FLOORS-1:0] car_clr, up_clr, dn_clr;
    logic                  loc_valid, here, any_above, any_below, near_up;

    logic [FLOOR_W-1:0] a_lo_above, a_hi_above, a_hi_below, a_lo_below;
    logic               a_hi_above_found, a_lo_below_found;
    logic [FLOOR_W-1:0] u_lo_above, u_hi_above, u_hi_below, u_lo_below;
    logic               u_lo_above_found, u_hi_above_found, u_hi_below_found, u_lo_below_found;
    logic [FLOOR_W-1:0] d_lo_above, d_hi_above, d_hi_below, d_lo_below;
    logic               d_lo_above_found, d_hi_above_found, d_hi_below_found, d_lo_below_found;
    logic               unused_search;

    assign all_req   = car_lamp | up_lamp | dn_lamp;
    assign pending   = |all_req;
    assign loc_valid = (location != '0) && (location <= FLOOR_W'(NUM_FLOORS));

    always_comb begin
        at_loc = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            at_loc[f] = (location == FLOOR_W'(f + 1));
        end
    end

    assign here = |(all_req & at_loc);

    floor_search #(.NUM_FLOORS(NUM_FLOORS)) u_search_all (
        .req            (all_req),
        .location       (location),
        .lo_above       (a_lo_above),
        .lo_above_found (any_above),
        .hi_above       (a_hi_above),
        .hi_above_found (a_hi_above_found),
        .hi_below       (a_hi_below),
        .hi_below_found (any_below),
        .lo_below       (a_lo_below),
        .lo_below_found (a_lo_below_found)
    );

    // Stops that suit an upward sweep: car calls and up calls.
    floor_search #(.NUM_FLOORS(NUM_FLOORS)) u_search_up (
        .req            (car_lamp | up_lamp),
        .location       (location),
        .lo_above       (u_lo_above),
        .lo_above_found (u_lo_above_found),
        .hi_above       (u_hi_above),
        .hi_above_found (u_hi_above_found),
        .hi_below       (u_hi_below),
        .hi_below_found (u_hi_below_found),
        .lo_below       (u_lo_below),
        .lo_below_found (u_lo_below_found)
    );

    floor_search #(.NUM_FLOORS(NUM_FLOORS)) u_search_dn (
        .req            (car_lamp | dn_lamp),
        .location       (location),
        .lo_above       (d_lo_above),
        .lo_above_found (d_lo_above_found),
        .hi_above       (d_hi_above),
        .hi_above_found (d_hi_above_found),
        .hi_below       (d_hi_below),
        .hi_below_found (d_hi_below_found),
        .lo_below       (d_lo_below),
        .lo_below_found (d_lo_below_found)
    );

    assign unused_search = ^{u_hi_above, u_hi_above_found, u_hi_below, u_hi_below_found,
                             u_lo_below, u_lo_below_found, d_lo_above, d_lo_above_found,
                             d_hi_above, d_hi_above_found, d_lo_below, d_lo_below_found};

    // Ties between equally distant floors resolve upward.
    assign near_up = any_above &&
                     (!any_below || ((a_lo_above - location) <= (location - a_hi_below)));

    // A hall call for the opposite direction is served too when the sweep ends here.
    always_comb begin
        car_clr = '0;
        up_clr  = '0;
        dn_clr  = '0;
        if (car_state == ST_OPEN) begin
            car_clr = at_loc;
            case (dir_q)
                DIR_UP: begin
                    up_clr = at_loc;
                    if (!any_above) dn_clr = at_loc;
                end
                DIR_DOWN: begin
                    dn_clr = at_loc;
                    if (!any_below) up_clr = at_loc;
                end
                default: begin
                    up_clr = at_loc;
                    dn_clr = at_loc;
                end
            endcase
        end
    end

    always_comb begin
        dir_d = dir_q;
        if (loc_valid && ((car_state == ST_OPEN) || (car_state == ST_STOP))) begin
            case (dir_q)
                DIR_IDLE: begin
                    if (!here) begin
                        if (near_up)        dir_d = DIR_UP;
                        else if (any_below) dir_d = DIR_DOWN;
                    end
                end
                DIR_UP: begin
                    if (any_above)      dir_d = DIR_UP;
                    else if (any_below) dir_d = DIR_DOWN;
                    else                dir_d = DIR_IDLE;
                end
                DIR_DOWN: begin
                    if (any_below)      dir_d = DIR_DOWN;
                    else if (any_above) dir_d = DIR_UP;
                    else                dir_d = DIR_IDLE;
                end
                default: dir_d = DIR_IDLE;
            endcase
        end
    end

    always_comb begin
        dest_d = dest_q;
        if (loc_valid) begin
            if (!pending) begin
                dest_d = location;
            end else begin
                case (dir_q)
                    DIR_UP: begin
                        if (u_lo_above_found)      dest_d = u_lo_above;
                        else if (a_hi_above_found) dest_d = a_hi_above;
                        else                       dest_d = location;
                    end
                    DIR_DOWN: begin
                        if (d_hi_below_found)      dest_d = d_hi_below;
                        else if (a_lo_below_found) dest_d = a_lo_below;
                        else                       dest_d = location;
                    end
                    default: begin
                        if (here)           dest_d = location;
                        else if (near_up)   dest_d = a_lo_above;
                        else if (any_below) dest_d = a_hi_below;
                        else                dest_d = location;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            car_lamp <= '0;
            up_lamp  <= '0;
            dn_lamp  <= '0;
            dir_q    <= DIR_IDLE;
            dest_q   <= FLOOR_W'(1);
        end else if (enable) begin
            car_lamp <= (car_lamp | car_btn) & ~car_clr;
            up_lamp  <= (up_lamp | (hall_up & UP_MASK)) & ~up_clr;
            dn_lamp  <= (dn_lamp | (hall_dn & DN_MASK)) & ~dn_clr;
            dir_q    <= dir_d;
            dest_q   <= dest_d;
        end
    end

    assign dest = dest_q;
    assign dir  = dir_q;

endmodule

// File: tb/tb_request_scheduler.sv
// Directed bench for request_scheduler: stimulus pushes cycle-tagged expected
// values into a scoreboard that a negedge monitor drains and compares.
module tb_request_scheduler;
    import elev_pkg::*;

    localparam int K_DEST = 0;
    localparam int K_DIR  = 1;
    localparam int K_CAR  = 2;
    localparam int K_UP   = 3;
    localparam int K_DN   = 4;
    localparam int K_PEND = 5;

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [4:0] car_btn, hall_up, hall_dn;
    logic [2:0] location;
    logic [1:0] car_state;
    logic [2:0] dest;
    logic [1:0] dir;
    logic [4:0] car_lamp, up_lamp, dn_lamp;
    logic       pending;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];

    request_scheduler #(.NUM_FLOORS(5)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .car_btn   (car_btn),
        .hall_up   (hall_up),
        .hall_dn   (hall_dn),
        .location  (location),
        .car_state (car_state),
        .dest      (dest),
        .dir       (dir),
        .car_lamp  (car_lamp),
        .up_lamp   (up_lamp),
        .dn_lamp   (dn_lamp),
        .pending   (pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Insert keeping the queue ordered by the cycle at which each check is due.
    function automatic void push(int dly, int kind, int val, string name);
        exp_t e;
        int   i;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        i = sbq.size();
        while (i > 0 && sbq[i-1].cyc > e.cyc) i--;
        sbq.insert(i, e);
    endfunction

    function automatic int actual(int kind);
        case (kind)
            K_DEST:  return int'(dest);
            K_DIR:   return int'(dir);
            K_CAR:   return int'(car_lamp);
            K_UP:    return int'(up_lamp);
            K_DN:    return int'(dn_lamp);
            default: return int'(pending);
        endcase
    endfunction

    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e   = sbq.pop_front();
                act = actual(e.kind);
                vectors++;
                if (act != e.val) begin
                    miscompares++;
                    $display("FAIL %s cyc %0d: got %0d, expected %0d", e.name, cyc, act, e.val);
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(logic [2:0] loc);
        resetn    = 1'b0;
        enable    = 1'b1;
        car_btn   = '0;
        hall_up   = '0;
        hall_dn   = '0;
        car_state = ST_STOP;
        location  = loc;
        tick(1);
        resetn = 1'b1;
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        enable    = 1'b1;
        car_btn   = '0;
        hall_up   = '0;
        hall_dn   = '0;
        location  = 3'd1;
        car_state = ST_STOP;
        tick(2);
        resetn = 1'b1;
        push(0, K_DEST, 1, "rst_dest");
        push(0, K_DIR,  0, "rst_dir");
        push(0, K_PEND, 0, "rst_pending");
        push(0, K_CAR,  0, "rst_car_lamp");
        tick(1);

        // Car call to floor 4 from floor 1, then door opens at 4.
        car_btn = 5'b01000;
        push(1, K_CAR,  8, "c4_lamp");
        push(1, K_DEST, 1, "c4_dest_n1");
        push(2, K_DEST, 4, "c4_dest");
        push(2, K_DIR,  1, "c4_dir_up");
        tick(1);
        car_btn = '0;
        tick(1);
        location  = 3'd4;
        car_state = ST_OPEN;
        push(1, K_CAR,  0, "c4_cleared");
        push(1, K_DIR,  0, "c4_dir_idle");
        push(1, K_DEST, 4, "c4_dest_hold");
        tick(1);
        car_state = ST_STOP;
        push(1, K_PEND, 0, "c4_pending");
        tick(3);

        // Equidistant requests from idle: upper floor wins.
        do_reset(3'd3);
        car_btn = 5'b01010;
        push(1, K_CAR,  10, "tie_lamps");
        push(2, K_DIR,  1,  "tie_dir_up");
        push(2, K_DEST, 4,  "tie_dest");
        tick(1);
        car_btn = '0;
        tick(3);

        // Moving up toward 5: hall-up at 3 retargets.
        do_reset(3'd1);
        car_btn = 5'b10000;
        tick(1);
        car_btn = '0;
        tick(1);
        push(0, K_DEST, 5, "sweep_dest5");
        push(0, K_DIR,  1, "sweep_dir_up");
        location  = 3'd2;
        car_state = ST_UP;
        hall_up   = 5'b00100;
        push(1, K_UP,   4, "hu3_lamp");
        push(1, K_DEST, 5, "hu3_dest_n1");
        push(2, K_DEST, 3, "hu3_retarget");
        push(2, K_DIR,  1, "hu3_dir_hold");
        tick(1);
        hall_up = '0;
        tick(3);

        // Same sweep: hall-down at 3 is behind the sweep direction, no retarget.
        do_reset(3'd1);
        car_btn = 5'b10000;
        tick(1);
        car_btn = '0;
        tick(1);
        location  = 3'd2;
        car_state = ST_UP;
        hall_dn   = 5'b00100;
        push(1, K_DN,   4, "hd3_lamp");
        push(2, K_DEST, 5, "hd3_no_retarget");
        push(3, K_DEST, 5, "hd3_no_retarget_2");
        tick(1);
        hall_dn = '0;
        tick(3);

        // Turnaround: only a down call above, then reversal toward floor 1.
        do_reset(3'd3);
        hall_dn = 5'b10000;
        push(1, K_DN,   16, "turn_lamp");
        push(2, K_DIR,  1,  "turn_dir_up");
        push(2, K_DEST, 5,  "turn_dest_idle");
        push(3, K_DEST, 5,  "turn_dest_up");
        tick(1);
        hall_dn = '0;
        tick(2);
        location  = 3'd5;
        car_state = ST_OPEN;
        push(1, K_DN,   0, "turn_dn_cleared");
        push(1, K_DIR,  0, "turn_dir_idle");
        push(1, K_DEST, 5, "turn_dest_at5");
        tick(1);
        car_state = ST_STOP;
        car_btn   = 5'b00001;
        push(1, K_CAR,  1, "rev_lamp");
        push(2, K_DIR,  2, "rev_dir_down");
        push(2, K_DEST, 1, "rev_dest");
        tick(1);
        car_btn = '0;
        tick(3);

        // Clear beats set at the open floor; masked hall bits never latch.
        do_reset(3'd3);
        car_state = ST_OPEN;
        car_btn   = 5'b00100;
        hall_up   = 5'b10000;
        hall_dn   = 5'b00001;
        push(1, K_CAR,  0, "hold_c3_1");
        push(2, K_CAR,  0, "hold_c3_2");
        push(1, K_UP,   0, "top_up_ignored");
        push(1, K_DN,   0, "bot_dn_ignored");
        push(2, K_PEND, 0, "ignored_pending");
        tick(2);
        car_btn   = '0;
        hall_up   = '0;
        hall_dn   = '0;
        car_state = ST_STOP;
        tick(3);

        // enable low freezes everything; invalid location lets lamps latch but holds dest.
        do_reset(3'd1);
        car_btn = 5'b00100;
        tick(1);
        car_btn = '0;
        tick(1);
        push(0, K_DEST, 3, "en_setup_dest");
        enable   = 1'b0;
        location = 3'd5;
        car_btn  = 5'b00010;
        push(1, K_CAR,  4, "en0_no_set");
        push(2, K_CAR,  4, "en0_no_set_2");
        push(2, K_DEST, 3, "en0_dest_hold");
        push(2, K_DIR,  1, "en0_dir_hold");
        tick(1);
        car_btn = '0;
        tick(1);
        enable   = 1'b1;
        location = 3'd0;
        car_btn  = 5'b00010;
        push(1, K_CAR,  6, "loc0_set");
        push(2, K_DEST, 3, "loc0_dest_hold");
        tick(1);
        car_btn = '0;
        tick(2);

        // Asynchronous reset mid-run with requests latched.
        resetn = 1'b0;
        push(0, K_CAR,  0, "mid_rst_car");
        push(0, K_DEST, 1, "mid_rst_dest");
        push(0, K_DIR,  0, "mid_rst_dir");
        tick(1);
        location = 3'd1;
        resetn   = 1'b1;
        push(0, K_CAR,  0, "post_rst_car");
        push(0, K_DEST, 1, "post_rst_dest");
        push(0, K_PEND, 0, "post_rst_pending");
        tick(3);

        for (int i = 0; i < 50 && sbq.size() > 0; i++) tick(1);
        if (sbq.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d checks left, expected 0", sbq.size());
            miscompares += sbq.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
